mcycle_bus_sequencer: RTL and testbench
=======================================

Name: mcycle_bus_sequencer

Overview:
Parametrised T-phase/M-cycle sequencer that drives the CPU-side bus for one micro-cycle descriptor at a time. It generalises the fixed four-phase CPU timing and adds:
- configurable widths and cycle depth
- bus wait states through a `bus_ready` handshake
- descriptor-valid stalling
- a sticky sequencing-error flag

It sits between the control-word ROM/decoder (which supplies per-M-cycle descriptors) and `Bus_if`. It emits strobes that tell the register/ALU/IDU datapath when to apply an M-cycle.

Parameters:
- `ADDR_W`, 16, bus address width
- `DATA_W`, 8, bus data width
- `MAX_CYCLES`, 6, maximum M-cycles per instruction; index `MAX_CYCLES-1` is the final/skip cycle
- `CYC_W`, `$clog2(MAX_CYCLES)`, width of the cycle index
- `TIMEOUT`, 16, wait-state limit in clocks (used only with the optional feature)

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `step_en`  in  1  clock enable; 0 freezes all state and outputs
- `uop_valid`  in  1  descriptor for the current cycle index is valid
- `uop_addr`  in  `ADDR_W`  address for this M-cycle
- `uop_op`  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none, sets `seq_error`)
- `uop_wdata`  in  `DATA_W`  write data
- `uop_last`  in  1  this M-cycle is the last of the instruction
- `uop_skip`  in  1  condition failed; sampled at T4
- `bus_addr`  out  `ADDR_W`  bus address
- `bus_read_en`  out  1  read request
- `bus_write_en`  out  1  write request
- `bus_wdata`  out  `DATA_W`  write data
- `bus_rdata`  in  `DATA_W`  read data
- `bus_ready`  in  1  target accepted/completed the transfer
- `rdata_q`  out  `DATA_W`  captured read data
- `rdata_valid`  out  1  one-clock pulse when `rdata_q` updates
- `t_phase`  out  2  current phase, 0..3 = T1..T4
- `cycle_idx`  out  `CYC_W`  current M-cycle index
- `exec_strobe`  out  1  one-clock pulse in T4; datapath applies IDU/ALU/misc ops
- `instr_done`  out  1  one-clock pulse in T4 of the instruction's final M-cycle
- `instr_count`  out  32  retired-instruction counter, wraps at 2^32
- `seq_error`  out  1  sticky error flag

Behaviour:
- **Reset.** `reset_n` low asynchronously clears every register: `t_phase`=T1, `cycle_idx`=0, `bus_addr`=0, enables=0, `bus_wdata`=0, `rdata_q`=0, all pulses=0, `instr_count`=0, `seq_error`=0. Reset asserted mid-transfer drops the enables immediately; no T4 strobe is produced.
- **Clock enable.** When `step_en`=0, nothing advances and pulses are forced to 0.
- **T1.** If `uop_valid`=0, remain in T1 with enables low (stall). Otherwise latch `bus_addr`←`uop_addr`, and latch `uop_op`, `uop_last` and `uop_wdata` internally, then go to T2. Later descriptor changes within the M-cycle are ignored.
- **T2.** Assert the enable for the latched op:
  - read: `bus_read_en`=1
  - write: `bus_write_en`=1 and `bus_wdata`←latched `wdata`
  - none: both enables 0
  - Always go to T3.
- **T3, op none.** Go to T4 unconditionally.
- **T3, op read/write.** If `bus_ready`=0, stay in T3 with the enable held (wait state). If `bus_ready`=1:
  - read: `rdata_q`←`bus_rdata` and `rdata_valid` pulses
  - write: completes
  - go to T4
- **T4.** Deassert both enables and pulse `exec_strobe`. Next state:
  1. If `uop_skip`=1 and `cycle_idx` ≠ `MAX_CYCLES-1`: `cycle_idx`←`MAX_CYCLES-1`.
  2. Otherwise, if latched `last`=1: `cycle_idx`←0, pulse `instr_done`, increment `instr_count`.
  3. Otherwise, if `cycle_idx` = `MAX_CYCLES-1` (overflow): set `seq_error`, force `cycle_idx`←0, pulse `instr_done`, increment `instr_count`.
  4. Otherwise: `cycle_idx`+1.
  - Then go to T1.
- **Skip in final slot.** `uop_skip` is ignored when `cycle_idx` = `MAX_CYCLES-1`.
- **Latency.** Minimum M-cycle is 4 clocks; each wait-state clock adds one.
- **`seq_error`.** Cleared only by reset.

Optional Feature:
`MCYCLE_SEQ_TIMEOUT_EN`
- **Defined:** a wait counter runs while in T3 with a pending read/write and `bus_ready`=0. At `TIMEOUT` consecutive waiting clocks the transfer aborts:
  - enables drop
  - a read loads `rdata_q` with all-ones and pulses `rdata_valid`
  - `seq_error` is set
  - the sequencer proceeds to T4 normally
  - The counter clears on every entry to T3.
- **Undefined:** no counter exists, and the sequencer waits indefinitely for `bus_ready`.

Test Plan:
1. Reset → all outputs zero. Descriptors read 0x0100 (`last`=0), then write 0xC000 data 0x5A (`last`=1), `bus_ready`=1 → `bus_addr` 0x0100 then 0xC000; `rdata_valid` at T3 of cycle 0; `instr_done` at clock 8; `instr_count`=1.
2. Read 0xFF44 with `bus_ready` low for 3 clocks in T3 → `bus_read_en` held 4 clocks; T4 at clock 7; `rdata_q`=`bus_rdata` (0x91).
3. `uop_skip`=1 at T4 of cycle 1 → `cycle_idx` jumps to 5. Next descriptor (`last`=1) completes; `instr_done` pulses once.
4. Descriptors with `last`=0 for all 6 cycles → `seq_error`=1 after cycle 5; `cycle_idx` wraps to 0; `instr_count`+1.
5. `reset_n` driven low during T3 with `bus_write_en`=1 → enable drops the same instant; after release `t_phase`=T1 and `cycle_idx`=0. Separately, `uop_valid`=0 for 5 clocks → T1 held, no enables.
6. With `MCYCLE_SEQ_TIMEOUT_EN` and `TIMEOUT`=16, `bus_ready` stuck low → abort after 16 wait clocks; `rdata_q`=0xFF; `seq_error`=1.

Source files
------------

// File: rtl/mcycle_bus_sequencer_if.sv
// CPU-side bus bundle between the M-cycle sequencer (master) and the memory/bus fabric (slave).
interface mcycle_bus_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_read_en;
  logic              bus_write_en;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_addr, bus_read_en, bus_write_en, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_addr, bus_read_en, bus_write_en, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mcycle_bus_sequencer.sv
// T1..T4 / M-cycle bus sequencer with wait states, descriptor stalls and a sticky error flag.
// Optional bus-timeout abort is built in when MCYCLE_SEQ_TIMEOUT_EN is defined.
module mcycle_bus_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MAX_CYCLES = 6,
  parameter int CYC_W      = $clog2(MAX_CYCLES),
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step_en,
  input  logic              uop_valid,
  input  logic [ADDR_W-1:0] uop_addr,
  input  logic [1:0]        uop_op,
  input  logic [DATA_W-1:0] uop_wdata,
  input  logic              uop_last,
  input  logic              uop_skip,
  mcycle_bus_sequencer_if.master bus,
  output logic [DATA_W-1:0] rdata_q,
  output logic              rdata_valid,
  output logic [1:0]        t_phase,
  output logic [CYC_W-1:0]  cycle_idx,
  output logic              exec_strobe,
  output logic              instr_done,
  output logic [31:0]       instr_count,
  output logic              seq_error
);
  typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} phase_t;

  localparam logic [1:0]       OP_NONE  = 2'b00;
  localparam logic [1:0]       OP_READ  = 2'b01;
  localparam logic [1:0]       OP_WRITE = 2'b10;
  localparam logic [1:0]       OP_RSVD  = 2'b11;
  localparam logic [CYC_W-1:0] LAST_IDX = CYC_W'(MAX_CYCLES - 1);

  phase_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              rd_en_reg, rd_en_next;
  logic              wr_en_reg, wr_en_next;
  logic [DATA_W-1:0] wdata_out_reg, wdata_out_next;
  logic [DATA_W-1:0] wdata_lat_reg, wdata_lat_next;
  logic [1:0]        op_reg, op_next;
  logic              last_reg, last_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              rdata_valid_reg, rdata_valid_next;
  logic [CYC_W-1:0]  idx_reg, idx_next;
  logic [31:0]       count_reg, count_next;
  logic              err_reg, err_next;
  logic              skip_taken;
  logic              retire;

`ifdef MCYCLE_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  // Skip is meaningless in the final slot; otherwise it overrides retirement.
  assign skip_taken = uop_skip && (idx_reg != LAST_IDX);
  assign retire     = !skip_taken && (last_reg || idx_reg == LAST_IDX);

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    rd_en_next       = rd_en_reg;
    wr_en_next       = wr_en_reg;
    wdata_out_next   = wdata_out_reg;
    wdata_lat_next   = wdata_lat_reg;
    op_next          = op_reg;
    last_next        = last_reg;
    rdata_next       = rdata_reg;
    rdata_valid_next = step_en ? 1'b0 : rdata_valid_reg;
    idx_next         = idx_reg;
    count_next       = count_reg;
    err_next         = err_reg;
`ifdef MCYCLE_SEQ_TIMEOUT_EN
    wait_cnt_next    = wait_cnt_reg;
`endif
    if (step_en) begin
      unique case (state_reg)
        T1: begin
          rd_en_next = 1'b0;
          wr_en_next = 1'b0;
          if (uop_valid) begin
            addr_next      = uop_addr;
            op_next        = (uop_op == OP_RSVD) ? OP_NONE : uop_op;
            last_next      = uop_last;
            wdata_lat_next = uop_wdata;
            if (uop_op == OP_RSVD) err_next = 1'b1;
            state_next     = T2;
          end
        end
        T2: begin
          // Enables are registered here so they are visible for exactly the T3 clocks.
          rd_en_next = (op_reg == OP_READ);
          wr_en_next = (op_reg == OP_WRITE);
          if (op_reg == OP_WRITE) wdata_out_next = wdata_lat_reg;
`ifdef MCYCLE_SEQ_TIMEOUT_EN
          wait_cnt_next = '0;
`endif
          state_next = T3;
        end
        T3: begin
          if (op_reg == OP_NONE) begin
            state_next = T4;
          end else if (bus.bus_ready) begin
            rd_en_next = 1'b0;
            wr_en_next = 1'b0;
            if (op_reg == OP_READ) begin
              rdata_next       = bus.bus_rdata;
              rdata_valid_next = 1'b1;
            end
            state_next = T4;
          end else begin
`ifdef MCYCLE_SEQ_TIMEOUT_EN
            if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
              rd_en_next = 1'b0;
              wr_en_next = 1'b0;
              err_next   = 1'b1;
              if (op_reg == OP_READ) begin
                rdata_next       = '1;
                rdata_valid_next = 1'b1;
              end
              state_next = T4;
            end else begin
              wait_cnt_next = wait_cnt_reg + 1'b1;
            end
`endif
          end
        end
        T4: begin
          rd_en_next = 1'b0;
          wr_en_next = 1'b0;
          if (skip_taken) begin
            idx_next = LAST_IDX;
          end else if (retire) begin
            if (!last_reg) err_next = 1'b1;
            idx_next   = '0;
            count_next = count_reg + 32'd1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
          state_next = T1;
        end
        default: state_next = T1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= T1;
      addr_reg        <= '0;
      rd_en_reg       <= 1'b0;
      wr_en_reg       <= 1'b0;
      wdata_out_reg   <= '0;
      wdata_lat_reg   <= '0;
      op_reg          <= OP_NONE;
      last_reg        <= 1'b0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      idx_reg         <= '0;
      count_reg       <= '0;
      err_reg         <= 1'b0;
`ifdef MCYCLE_SEQ_TIMEOUT_EN
      wait_cnt_reg    <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      rd_en_reg       <= rd_en_next;
      wr_en_reg       <= wr_en_next;
      wdata_out_reg   <= wdata_out_next;
      wdata_lat_reg   <= wdata_lat_next;
      op_reg          <= op_next;
      last_reg        <= last_next;
      rdata_reg       <= rdata_next;
      rdata_valid_reg <= rdata_valid_next;
      idx_reg         <= idx_next;
      count_reg       <= count_next;
      err_reg         <= err_next;
`ifdef MCYCLE_SEQ_TIMEOUT_EN
      wait_cnt_reg    <= wait_cnt_next;
`endif
    end
  end

  assign bus.bus_addr     = addr_reg;
  assign bus.bus_read_en  = rd_en_reg;
  assign bus.bus_write_en = wr_en_reg;
  assign bus.bus_wdata    = wdata_out_reg;
  assign rdata_q          = rdata_reg;
  assign rdata_valid      = rdata_valid_reg && step_en;
  assign t_phase          = state_reg;
  assign cycle_idx        = idx_reg;
  assign exec_strobe      = step_en && (state_reg == T4);
  assign instr_done       = exec_strobe && retire;
  assign instr_count      = count_reg;
  assign seq_error        = err_reg;
endmodule

// File: tb/tb_mcycle_bus_sequencer.sv
// Directed self-checking bench for mcycle_bus_sequencer (define MCYCLE_SEQ_TIMEOUT_EN to exercise the abort path).
module tb_mcycle_bus_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        step_en;
  logic        uop_valid;
  logic [15:0] uop_addr;
  logic [1:0]  uop_op;
  logic [7:0]  uop_wdata;
  logic        uop_last;
  logic        uop_skip;
  logic [7:0]  rdata_q;
  logic        rdata_valid;
  logic [1:0]  t_phase;
  logic [2:0]  cycle_idx;
  logic        exec_strobe;
  logic        instr_done;
  logic [31:0] instr_count;
  logic        seq_error;

  int check_cnt = 0;
  int pass_cnt  = 0;

  mcycle_bus_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bif ();

  mcycle_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .MAX_CYCLES(6), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .step_en(step_en), .uop_valid(uop_valid),
    .uop_addr(uop_addr), .uop_op(uop_op), .uop_wdata(uop_wdata), .uop_last(uop_last),
    .uop_skip(uop_skip), .bus(bif.master), .rdata_q(rdata_q), .rdata_valid(rdata_valid),
    .t_phase(t_phase), .cycle_idx(cycle_idx), .exec_strobe(exec_strobe),
    .instr_done(instr_done), .instr_count(instr_count), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one M-cycle from T1 up to (not past) its T4 clock; clocks counts T1..T4 inclusive.
  task automatic do_mcycle(input logic [15:0] addr, input logic [1:0] op, input logic [7:0] wd,
                           input logic last, input logic skip, input int waits, input logic [7:0] rd,
                           output int clocks, output int en_clocks,
                           output logic [15:0] addr_seen, output logic [7:0] wdata_seen);
    int  t3 = 0;
    bit  done = 0;
    uop_valid = 1'b1; uop_addr = addr; uop_op = op; uop_wdata = wd;
    uop_last = last;  uop_skip = skip;
    bif.bus_rdata = rd; bif.bus_ready = (waits == 0);
    clocks = 1; en_clocks = 0; addr_seen = '0; wdata_seen = '0;
    for (int n = 0; n < 64; n++) begin
      tick();
      clocks++;
      if (bif.bus_read_en || bif.bus_write_en) en_clocks++;
      if (t_phase == 2'd1) addr_seen = bif.bus_addr;
      if (t_phase == 2'd2) begin
        t3++;
        if (t3 == 1) wdata_seen = bif.bus_wdata;
        bif.bus_ready = (t3 > waits);
      end
      if (t_phase == 2'd3) begin
        done = 1;
        break;
      end
    end
    check("t4_reached", 32'(done), 32'd1);
    $display("txn addr=0x%04h op=%0d last=%0d skip=%0d waits=%0d clocks=%0d en_clocks=%0d",
             addr, op, last, skip, waits, clocks, en_clocks);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          clk_n, en_n, total;
    logic [15:0] a_seen;
    logic [7:0]  w_seen;
    bit          stall_bad;

    reset_n = 1'b0; step_en = 1'b1; uop_valid = 1'b0; uop_addr = '0; uop_op = '0;
    uop_wdata = '0; uop_last = 1'b0; uop_skip = 1'b0;
    bif.bus_rdata = '0; bif.bus_ready = 1'b0;
    repeat (2) tick();
    check("rst_state", {t_phase, cycle_idx, bif.bus_read_en, bif.bus_write_en, rdata_valid,
                        exec_strobe, instr_done, seq_error}, 32'd0);
    check("rst_addr_data", {bif.bus_addr, bif.bus_wdata, rdata_q}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    reset_n = 1'b1;

    // 1: read 0x0100 then write 0xC000/0x5A closing the instruction
    do_mcycle(16'h0100, 2'b01, 8'h00, 1'b0, 1'b0, 0, 8'h3C, clk_n, en_n, a_seen, w_seen);
    total = clk_n;
    check("t1_rd_addr", 32'(a_seen), 32'h0100);
    check("t1_rd_clocks", 32'(clk_n), 32'd4);
    check("t1_rdata", {rdata_valid, rdata_q}, 32'h13C);
    check("t1_c0_t4", {exec_strobe, instr_done}, 32'b10);
    tick();
    check("t1_idx1", 32'(cycle_idx), 32'd1);
    do_mcycle(16'hC000, 2'b10, 8'h5A, 1'b1, 1'b0, 0, 8'h00, clk_n, en_n, a_seen, w_seen);
    total += clk_n;
    check("t1_wr_addr", 32'(a_seen), 32'hC000);
    check("t1_wr_data", 32'(w_seen), 32'h5A);
    check("t1_done_clock", 32'(total), 32'd8);
    check("t1_done", {exec_strobe, instr_done}, 32'b11);
    tick();
    check("t1_count", instr_count, 32'd1);
    check("t1_idx0", 32'(cycle_idx), 32'd0);

    // 2: read with three wait states
    do_mcycle(16'hFF44, 2'b01, 8'h00, 1'b1, 1'b0, 3, 8'h91, clk_n, en_n, a_seen, w_seen);
    check("t2_en_clocks", 32'(en_n), 32'd4);
    check("t2_t4_clock", 32'(clk_n), 32'd7);
    check("t2_rdata", {rdata_valid, rdata_q}, 32'h191);
    tick();
    check("t2_count", instr_count, 32'd2);

    // 3: skip at cycle 1 jumps to slot 5; skip ignored in slot 5
    do_mcycle(16'h0000, 2'b00, 8'h00, 1'b0, 1'b0, 0, 8'h00, clk_n, en_n, a_seen, w_seen);
    tick();
    do_mcycle(16'h0001, 2'b00, 8'h00, 1'b0, 1'b1, 0, 8'h00, clk_n, en_n, a_seen, w_seen);
    check("t3_skip_no_done", {exec_strobe, instr_done}, 32'b10);
    tick();
    check("t3_idx5", 32'(cycle_idx), 32'd5);
    do_mcycle(16'h0005, 2'b01, 8'h00, 1'b1, 1'b1, 0, 8'h22, clk_n, en_n, a_seen, w_seen);
    check("t3_done", 32'(instr_done), 32'd1);
    tick();
    check("t3_after", {seq_error, cycle_idx}, 32'd0);
    check("t3_count", instr_count, 32'd3);

    // 4: six cycles without last overflow; freeze with step_en in the final T4
    for (int i = 0; i < 6; i++) begin
      do_mcycle(16'(16'h0200 + i), 2'b00, 8'h00, 1'b0, 1'b0, 0, 8'h00, clk_n, en_n, a_seen, w_seen);
      if (i < 5) tick();
    end
    check("t4_ovf_done", {instr_done, seq_error, cycle_idx}, {27'd0, 5'b10101});
    step_en = 1'b0;
    #1;
    check("t4_freeze_pulses", {exec_strobe, instr_done}, 32'b00);
    tick(); tick();
    check("t4_freeze_hold", {t_phase, cycle_idx}, {27'd0, 5'b11101});
    step_en = 1'b1;
    #1;
    check("t4_unfreeze", 32'(exec_strobe), 32'd1);
    tick();
    check("t4_ovf_after", {seq_error, cycle_idx}, {28'd0, 4'b1000});
    check("t4_count", instr_count, 32'd4);

    // 5: async reset during a waiting write, then a descriptor stall
    uop_valid = 1'b1; uop_addr = 16'h1234; uop_op = 2'b10; uop_wdata = 8'hA5;
    uop_last = 1'b1; uop_skip = 1'b0; bif.bus_ready = 1'b0;
    tick(); tick();
    check("t5_we_before", 32'(bif.bus_write_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_we_dropped", {bif.bus_write_en, t_phase}, 32'd0);
    uop_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_after_rst", {t_phase, cycle_idx, seq_error, exec_strobe}, 32'd0);
    check("t5_count_rst", instr_count, 32'd0);
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (t_phase != 2'd0 || bif.bus_read_en || bif.bus_write_en) stall_bad = 1;
    end
    check("t5_stall", 32'(stall_bad), 32'd0);

`ifdef MCYCLE_SEQ_TIMEOUT_EN
    // 6: bus_ready stuck low aborts after 16 waiting clocks
    do_mcycle(16'h4000, 2'b01, 8'h00, 1'b1, 1'b0, 1000, 8'h33, clk_n, en_n, a_seen, w_seen);
    check("t6_en_clocks", 32'(en_n), 32'd16);
    check("t6_clocks", 32'(clk_n), 32'd19);
    check("t6_abort", {seq_error, rdata_valid, rdata_q}, 32'h3FF);
    tick();
    check("t6_count", instr_count, 32'd1);
`endif

    // Reserved op behaves as none and flags the error
    do_mcycle(16'h2000, 2'b11, 8'h00, 1'b1, 1'b0, 0, 8'h00, clk_n, en_n, a_seen, w_seen);
    check("rsvd_no_enable", 32'(en_n), 32'd0);
    check("rsvd_clocks", 32'(clk_n), 32'd4);
    check("rsvd_err_done", {seq_error, instr_done}, 32'b11);
    uop_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
